// File: rtl/alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_arb
// Description : Round-robin arbiter/sequencer time-sharing one external
//               combinational ALU between two valid/ready requesters.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_arb #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_f,
    output logic             rsp0_z,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_f,
    output logic             rsp1_z,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_f,
    input  logic             alu_z,
    output logic             busy
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_resp  = 2'd2;

    logic [1:0]       r_state;
    logic             r_last_grant;
    logic             r_owner;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [SEL_W-1:0] r_sel;
    logic [WIDTH-1:0] r_f;
    logic             r_z;

    logic             w_grant;
    logic             w_rsp_hs;
    logic             w_open;
    logic             w_accept;

    // A lone requester always wins; on a tie the one not served last wins.
    always_comb begin
        w_grant = ~r_last_grant;
        if (req0_valid && !req1_valid) begin
            w_grant = 1'b0;
        end else if (req1_valid && !req0_valid) begin
            w_grant = 1'b1;
        end
    end

    assign w_rsp_hs = (r_state == c_st_resp) && (r_owner ? rsp1_ready : rsp0_ready);

    // Ready is combinational, so it is also gated by reset to drop at once.
    assign w_open     = rst_n && ((r_state == c_st_idle) || w_rsp_hs);
    assign req0_ready = w_open && req0_valid && !w_grant;
    assign req1_ready = w_open && req1_valid && w_grant;
    assign w_accept   = req0_ready || req1_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_sel        <= '0;
            r_f          <= '0;
            r_z          <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a          <= w_grant ? req1_a   : req0_a;
                r_b          <= w_grant ? req1_b   : req0_b;
                r_sel        <= w_grant ? req1_sel : req0_sel;
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
            end
            case (r_state)
                c_st_idle: begin
                    if (w_accept) begin
                        r_state <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_f     <= alu_f;
                    r_z     <= alu_z;
                    r_state <= c_st_resp;
                end
                c_st_resp: begin
                    if (w_rsp_hs) begin
                        r_state <= w_accept ? c_st_issue : c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign alu_a   = r_a;
    assign alu_b   = r_b;
    assign alu_sel = r_sel;

    assign rsp0_valid = (r_state == c_st_resp) && !r_owner;
    assign rsp1_valid = (r_state == c_st_resp) && r_owner;
    assign rsp0_f     = r_f;
    assign rsp0_z     = r_z;
    assign rsp1_f     = r_f;
    assign rsp1_z     = r_z;
    assign busy       = (r_state != c_st_idle);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_arb
// Description : Randomized scoreboard bench for alu_share_arb with an
//               external ALU model and a transaction-level arbitration model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_arb;

    localparam int WIDTH = 32;
    localparam int SEL_W = 5;

    localparam logic [4:0] c_sel_add  = 5'd0;
    localparam logic [4:0] c_sel_sub  = 5'd1;
    localparam logic [4:0] c_sel_or   = 5'd3;
    localparam logic [4:0] c_sel_xor  = 5'd4;
    localparam logic [4:0] c_sel_mul  = 5'd10;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sel;
        logic [31:0] f;
        logic        z;
    } op_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [SEL_W-1:0] req0_sel = '0, req1_sel = '0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [WIDTH-1:0] rsp0_f, rsp1_f;
    logic             rsp0_z, rsp1_z;
    logic [WIDTH-1:0] alu_a, alu_b, alu_f;
    logic [SEL_W-1:0] alu_sel;
    logic             alu_z;
    logic             busy;

    int  n_vec = 0;
    int  n_err = 0;
    int  cyc = 0;
    bit  rnd_ready = 1'b0;

    op_t cur0, cur1;
    op_t send_q0[$], send_q1[$], exp_q0[$], exp_q1[$];
    bit  glog_g[$];
    int  glog_c[$];

    initial forever #5 clk = ~clk;

    alu_share_arb #(.WIDTH(WIDTH), .SEL_W(SEL_W)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_sel(req0_sel), .rsp0_valid(rsp0_valid),
        .rsp0_ready(rsp0_ready), .rsp0_f(rsp0_f), .rsp0_z(rsp0_z),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_sel(req1_sel), .rsp1_valid(rsp1_valid),
        .rsp1_ready(rsp1_ready), .rsp1_f(rsp1_f), .rsp1_z(rsp1_z),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_f(alu_f), .alu_z(alu_z), .busy(busy)
    );

    // External RISC-V ALU; unknown selects give f=0, z=1.
    function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sel);
        logic [31:0] f;
        case (sel)
            5'd0:    f = a + b;
            5'd1:    f = a - b;
            5'd2:    f = a & b;
            5'd3:    f = a | b;
            5'd4:    f = a ^ b;
            5'd5:    f = a << b[4:0];
            5'd6:    f = a >> b[4:0];
            5'd7:    f = $signed(a) >>> b[4:0];
            5'd8:    f = {31'b0, $signed(a) < $signed(b)};
            5'd9:    f = {31'b0, a < b};
            5'd10:   f = a * b;
            default: f = 32'h0;
        endcase
        return {(f == 32'h0), f};
    endfunction

    always_comb {alu_z, alu_f} = alu_ref(alu_a, alu_b, alu_sel);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic op_t mk_op(input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] sel);
        op_t o;
        logic [32:0] r;
        r = alu_ref(a, b, sel);
        o.a = a; o.b = b; o.sel = sel; o.f = r[31:0]; o.z = r[32];
        return o;
    endfunction

    function automatic op_t rnd_op();
        logic [31:0] a, b;
        logic [4:0]  s;
        a = $urandom();
        b = ($urandom_range(0, 4) == 0) ? a : $urandom();
        s = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(11, 31)) : 5'($urandom_range(0, 10));
        return mk_op(a, b, s);
    endfunction

    task automatic drive_pins();
        req0_a   = req0_valid ? cur0.a   : $urandom();
        req0_b   = req0_valid ? cur0.b   : $urandom();
        req0_sel = req0_valid ? cur0.sel : 5'($urandom());
        req1_a   = req1_valid ? cur1.a   : $urandom();
        req1_b   = req1_valid ? cur1.b   : $urandom();
        req1_sel = req1_valid ? cur1.sel : 5'($urandom());
    endtask

    // One clock: note acceptances at the sample point, update drive after the edge.
    task automatic tick();
        bit t0, t1;
        @(negedge clk);
        t0 = req0_valid && req0_ready;
        t1 = req1_valid && req1_ready;
        if (t0) exp_q0.push_back(cur0);
        if (t1) exp_q1.push_back(cur1);
        @(posedge clk);
        #1;
        if (t0) req0_valid = 1'b0;
        if (t1) req1_valid = 1'b0;
        if (!req0_valid && send_q0.size() != 0) begin cur0 = send_q0.pop_front(); req0_valid = 1'b1; end
        if (!req1_valid && send_q1.size() != 0) begin cur1 = send_q1.pop_front(); req1_valid = 1'b1; end
        drive_pins();
        if (rnd_ready) begin
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic drain(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            done = (send_q0.size() == 0) && (send_q1.size() == 0) && !req0_valid && !req1_valid
                   && (exp_q0.size() == 0) && (exp_q1.size() == 0) && !busy;
            if (done) break;
            tick();
        end
        chk("drain_done", 64'(done), 64'd1);
    endtask

    // Called just after a rising edge; reset must act without a clock.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {rsp1_f, rsp0_f[26:0], req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 64'd0);
        exp_q0.delete();
        exp_q1.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        glog_g.delete();
        glog_c.delete();
    endtask

    // Monitor: transaction-level model of grant/timing plus response scoreboard.
    initial begin
        bit   m_pending, m_owner, m_last;
        int   m_age;
        bit   ev0, ev1, hs, open, g, er0, er1;
        bit   hold0, hold1;
        logic [32:0] held0, held1;
        op_t  e;
        m_pending = 0; m_owner = 0; m_last = 1; m_age = 0;
        hold0 = 0; hold1 = 0; held0 = '0; held1 = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                chk("rst_outputs", {rsp1_f, rsp0_f[26:0], req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy}, 64'd0);
                m_pending = 0; m_last = 1; m_age = 0; hold0 = 0; hold1 = 0;
            end else begin
                ev0 = m_pending && !m_owner && (m_age >= 1);
                ev1 = m_pending && m_owner && (m_age >= 1);
                chk("rsp_valid", {rsp1_valid, rsp0_valid}, {ev1, ev0});
                chk("busy", 64'(busy), 64'(m_pending));
                hs   = (ev0 && rsp0_ready) || (ev1 && rsp1_ready);
                open = !m_pending || hs;
                g    = (req0_valid && req1_valid) ? !m_last : req1_valid;
                er0  = open && req0_valid && !g;
                er1  = open && req1_valid && g;
                chk("req_ready", {req1_ready, req0_ready}, {er1, er0});
                if (rsp0_valid && hold0) chk("rsp0_hold", {rsp0_z, rsp0_f}, held0);
                if (rsp1_valid && hold1) chk("rsp1_hold", {rsp1_z, rsp1_f}, held1);
                hold0 = rsp0_valid && !rsp0_ready; held0 = {rsp0_z, rsp0_f};
                hold1 = rsp1_valid && !rsp1_ready; held1 = {rsp1_z, rsp1_f};
                if (rsp0_valid && rsp0_ready) begin
                    if (exp_q0.size() == 0) chk("rsp0_unexpected", 64'd1, 64'd0);
                    else begin e = exp_q0.pop_front(); chk("rsp0_result", {rsp0_z, rsp0_f}, {e.z, e.f}); end
                end
                if (rsp1_valid && rsp1_ready) begin
                    if (exp_q1.size() == 0) chk("rsp1_unexpected", 64'd1, 64'd0);
                    else begin e = exp_q1.pop_front(); chk("rsp1_result", {rsp1_z, rsp1_f}, {e.z, e.f}); end
                end
                if (req0_valid && req0_ready) begin glog_g.push_back(1'b0); glog_c.push_back(cyc); end
                else if (req1_valid && req1_ready) begin glog_g.push_back(1'b1); glog_c.push_back(cyc); end
                if (hs) m_pending = 0;
                if (er0 || er1) begin
                    m_pending = 1; m_owner = er1; m_last = er1; m_age = 0;
                end else if (m_pending) begin
                    m_age++;
                end
            end
        end
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;

        // Single op on requester 0, then zero result on requester 1.
        send_q0.push_back('{a: 32'd5, b: 32'd7, sel: c_sel_add, f: 32'd12, z: 1'b0});
        drain(20);
        send_q1.push_back('{a: 32'd9, b: 32'd9, sel: c_sel_sub, f: 32'd0, z: 1'b1});
        drain(20);

        // Tie straight after reset: requester 0 first, requester 1 on its handshake.
        @(posedge clk);
        do_reset();
        send_q0.push_back('{a: 32'hF0, b: 32'h0F, sel: c_sel_xor, f: 32'hFF, z: 1'b0});
        send_q1.push_back('{a: 32'd3, b: 32'd4, sel: c_sel_mul, f: 32'd12, z: 1'b0});
        drain(20);
        chk("tie_first_grant", (glog_g.size() != 0) ? 64'(glog_g[0]) : 64'd9, 64'd0);
        chk("tie_gap", (glog_c.size() == 2) ? 64'(glog_c[1] - glog_c[0]) : 64'd99, 64'd2);

        // Response backpressure with a competing request waiting.
        rsp0_ready = 1'b0;
        send_q0.push_back('{a: 32'd1, b: 32'd2, sel: c_sel_add, f: 32'd3, z: 1'b0});
        send_q1.push_back('{a: 32'h10, b: 32'h01, sel: c_sel_or, f: 32'h11, z: 1'b0});
        repeat (7) tick();
        chk("bp_busy", 64'(busy), 64'd1);
        chk("bp_req1_waiting", {req1_valid, req1_ready}, 2'b10);
        rsp0_ready = 1'b1;
        drain(20);

        // Fairness: both requesters saturated.
        for (int i = 0; i < 4; i++) begin
            send_q0.push_back(rnd_op());
            send_q1.push_back(rnd_op());
        end
        glog_g.delete();
        glog_c.delete();
        drain(40);
        chk("fair_count", 64'(glog_g.size()), 64'd8);
        for (int i = 0; i < 8 && i < glog_g.size(); i++) begin
            chk("fair_order", 64'(glog_g[i]), 64'(i % 2));
            if (i > 0) chk("fair_gap", 64'(glog_c[i] - glog_c[i-1]), 64'd2);
        end

        // Reset during ISSUE, with a tie waiting across the reset.
        send_q1.push_back(rnd_op());
        for (int i = 0; i < 10; i++) begin
            if (busy && !rsp0_valid && !rsp1_valid) break;
            tick();
        end
        chk("midop_in_issue", {busy, rsp0_valid, rsp1_valid}, 3'b100);
        cur0 = mk_op(32'd100, 32'd23, c_sel_add);
        cur1 = mk_op(32'd50, 32'd8, c_sel_sub);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        drive_pins();
        do_reset();
        drain(20);
        chk("midop_tie_grant", (glog_g.size() != 0) ? 64'(glog_g[0]) : 64'd9, 64'd0);

        // Randomized traffic with random response backpressure.
        rnd_ready = 1'b1;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) send_q0.push_back(rnd_op());
            if ($urandom_range(0, 3) == 0) send_q1.push_back(rnd_op());
            tick();
        end
        drain(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
- Two-requester round-robin arbiter and sequencer that time-shares one combinational RISC-V ALU instance.
- Requester 0 is the integer-pipeline EX stage; requester 1 is the branch/address-generation helper.
- Each requester issues operands and a 5-bit ALU select over a valid/ready handshake. It gets back the registered result and zero flag over a separate valid/ready response channel.
- Sits between the requesters and the ALU. The ALU itself is external and unmodified.

Parameters:
- WIDTH, 32, operand/result width.
- SEL_W, 5, ALU select width. Encodings are the ALU_sel SEL_* codes.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  WIDTH  operand a.
- req0_b  in  WIDTH  operand b.
- req0_sel  in  SEL_W  ALU select.
- rsp0_valid  out  1  result for requester 0 available.
- rsp0_ready  in  1  requester 0 consumes result.
- rsp0_f  out  WIDTH  result.
- rsp0_z  out  1  zero flag.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel, rsp1_valid, rsp1_ready, rsp1_f, rsp1_z: same as requester 0.
- alu_a  out  WIDTH  ALU operand a.
- alu_b  out  WIDTH  ALU operand b.
- alu_sel  out  SEL_W  ALU select.
- alu_f  in  WIDTH  ALU result.
- alu_z  in  1  ALU zero flag.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, last_grant=1 (so requester 0 wins first tie).
  - Operand/sel/owner/result registers = 0.
  - All ready/valid outputs = 0; rsp*_f=0, rsp*_z=0, busy=0.
  - Effective immediately, without waiting for clk.
- State machine: IDLE -> ISSUE -> RESP -> (IDLE or ISSUE).
- IDLE:
  - req_ready is combinational and only for the granted requester.
  - Grant rule: if only one valid, grant it. If both valid, grant the one not equal to last_grant.
  - On the handshake edge: latch a, b, sel, set owner=granted, last_grant=granted, go to ISSUE.
- ISSUE (exactly 1 cycle):
  - alu_a/alu_b/alu_sel are driven from the operand registers.
  - At the clock edge: capture alu_f/alu_z into the result registers, go to RESP.
- RESP:
  - rsp<owner>_valid=1 with the registered f/z. The other rsp_valid=0.
  - f/z/valid are held stable until rsp<owner>_ready=1.
  - On response handshake: if any req_valid is present in the same cycle, arbitrate exactly as in IDLE and assert that req_ready. Accept directly, going to ISSUE; otherwise go to IDLE.
  - No request is accepted in RESP before the response handshake.
- Latency and throughput:
  - Request accept at edge N gives rsp_valid from cycle N+2.
  - Sustained throughput is 1 op per 2 cycles with zero response backpressure.
- alu_a/alu_b/alu_sel are always driven from the operand registers, holding the last values in IDLE/RESP. The ALU output is sampled only in ISSUE.
- req*_ready=0 in ISSUE, and in RESP without a response handshake.
- Fairness: with both requesters continuously valid, grants strictly alternate. Neither requester waits more than one foreign operation.
- Requester operands are don't-care when the requester is not granted. Inputs do not need to be stable after acceptance.
- Invalid sel: passed through unchanged. The ALU's default yields f=0, z=1.
- Reset mid-operation: the in-flight op is discarded with no response. After reset, requester 0 again wins the first tie.
- busy=1 in ISSUE and RESP.

Test Plan:
- Single op: req0 sends a=5, b=7, sel=SEL_ADD at edge N. Required response: req0_ready=1 that cycle; rsp0_valid=1 at N+2 with f=12, z=0; rsp1_valid stays 0.
- Zero flag and requester 1: req1 sends a=9, b=9, sel=SEL_SUB. Required response: rsp1_f=0, rsp1_z=1.
- Tie after reset: both valid, req0 sends SEL_XOR of 0xF0 and 0x0F; req1 sends SEL_MUL of 3 and 4. Required response: req0 is granted first and gets f=0xFF; req1 is then accepted in the same cycle as rsp0's handshake and gets f=12.
- Backpressure: hold rsp0_ready=0 for 5 cycles. Required response: rsp0_valid and f stay stable, req1_ready=0 throughout, busy=1; on release, req1 is accepted in the handshake cycle.
- Fairness: both requesters always valid with rsp_ready=1 for 8 ops. Required response: grant order 0,1,0,1,0,1,0,1; ops issue every 2 cycles.
- Reset mid-op: assert rst_n=0 during ISSUE. Required response: all valid/ready = 0 immediately with no response produced; after release, the next tie grants req0.
